// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg
//   Types and constants shared by the FIFO read-side packer and its idle timer.
//   Contents:
//     pack_state_t  packer state (FILL, HOLD)
//     lane_w()      lane index width for a given lane count
//     KEEP_RST_BIT  reset value of each bit of the keep mask
package fifo_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Never return 0 so a lane index is always at least 1 bit wide.
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam logic KEEP_RST_BIT = 1'b0;

endpackage

// File: rtl/fifo_pack_tmo.sv
// fifo_pack_tmo
//   Idle counter that flushes a partially packed word. It counts cycles in
//   which run=1 and raises expire once the count reaches TMO. It then holds
//   that count until clr.
//   Ports:
//     rdclk   in   read-domain clock
//     rdrst   in   synchronous active-high reset
//     clr     in   clear the count (takes priority over run)
//     run     in   advance the count by one
//     expire  out  count has reached TMO
module fifo_pack_tmo #(
  parameter int TMO = 16
) (
  input  logic rdclk,
  input  logic rdrst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TC  = CW'(TMO);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge rdclk) begin
    if (rdrst || clr) begin
      cnt_q <= '0;
    end else if (run && !expire) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign expire = (cnt_q == TC);

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side packer behind a first-word-fall-through async FIFO. It pops
//   LANES consecutive entries and packs them little-endian into one word
//   (lane 0 = first entry). It then presents the word with valid/ready.
//   Optional macro FIFO_PACK_TIMEOUT_EN: after TMO idle cycles, a partial
//   word is flushed with a partial keep mask.
//   Ports:
//     rdclk       in   read-domain clock
//     rdrst       in   synchronous active-high reset
//     fifo_empty  in   FIFO empty flag
//     fifo_data   in   FIFO head entry (valid when fifo_empty=0)
//     fifo_pop    out  pop strobe (combinational)
//     out_valid   out  packed word available
//     out_ready   in   downstream accepts the word
//     out_data    out  packed word, lane 0 at [WIDTH-1:0]
//     out_keep    out  per-lane valid mask
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int TMO   = 16
) (
  input  logic                   rdclk,
  input  logic                   rdrst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep
);

  // state | meaning
  // FILL  | popping entries into lanes idx..LANES-1
  // HOLD  | word presented, waiting for out_ready

  localparam int IW = lane_w(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  if (LANES < 2) begin : g_bad_lanes
    $error("fifo_rd_packer: LANES must be >= 2");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("fifo_rd_packer: TMO must be >= 1");
  end

  pack_state_t            state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   tmo_fire;

`ifdef FIFO_PACK_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_run;
  logic tmo_expire;

  // Holding the counter clear throughout HOLD leaves it at zero on FILL entry.
  assign tmo_clr = fifo_pop || (state_q == HOLD);
  assign tmo_run = (state_q == FILL) && (idx_q != '0) && fifo_empty;

  fifo_pack_tmo #(
    .TMO(TMO)
  ) u_tmo (
    .rdclk (rdclk),
    .rdrst (rdrst),
    .clr   (tmo_clr),
    .run   (tmo_run),
    .expire(tmo_expire)
  );

  assign tmo_fire = tmo_expire && (idx_q != '0);
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= {LANES{KEEP_RST_BIT}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  always_comb begin
    fifo_pop = 1'b0;
    if (!rdrst) begin
      case (state_q)
        FILL:    fifo_pop = !fifo_empty;
        HOLD:    fifo_pop = !fifo_empty && out_ready;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    keep_d  = keep_q;
    case (state_q)
      FILL: begin
        if (fifo_pop) begin
          data_d[idx_q*WIDTH +: WIDTH] = fifo_data;
          keep_d[idx_q]                = 1'b1;
          if (idx_q == LAST) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end else if (tmo_fire) begin
          state_d = HOLD;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          data_d  = '0;
          keep_d  = '0;
          idx_d   = '0;
          // Popping into lane 0 during the handoff avoids a bubble between words.
          if (fifo_pop) begin
            data_d[WIDTH-1:0] = fifo_data;
            keep_d[0]         = 1'b1;
            idx_d             = ONE;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side packer that sits directly downstream of the async FIFO, in the read clock domain. It drains the FIFO's first-word-fall-through byte stream through `pop`/`empty`, assembles LANES consecutive entries into one wide word, and presents that word to the next stage with a valid/ready handshake. An optional timeout flushes a partially filled word so trailing bytes are not stranded.

## Interface
- `WIDTH`, 8: FIFO entry width in bits.
- `LANES`, 4: entries packed per output word; must be ≥2.
- `TMO`, 16: idle cycles before a partial word is flushed; must be ≥1; used only with the timeout macro.

- `rdclk`  in  1  read-domain clock; the only clock.
- `rdrst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO head entry; valid whenever `fifo_empty`=0.
- `fifo_pop`  out  1  pop strobe; combinational.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WIDTH*LANES  packed word; lane 0 is at bits [WIDTH-1:0].
- `out_keep`  out  LANES  per-lane valid mask.

## Operation
- Two states:
  - FILL: collecting bytes.
  - HOLD: word presented, waiting for `out_ready`.
- Lane index `idx` is `$clog2(LANES)` bits wide. The first popped entry goes to lane 0. Lanes are filled in ascending order (little-endian).
- `fifo_pop` is driven as:
  - `!fifo_empty` in FILL;
  - `!fifo_empty && out_ready` in HOLD;
  - forced 0 while `rdrst`=1.
- In FILL, on pop:
  - `fifo_data` is written into lane `idx` and `keep[idx]` is set.
  - If `idx`=LANES-1: go to HOLD and set `idx`=0. Otherwise `idx`+1.
- In HOLD, `out_valid`=1. When `out_ready`=1, the word is consumed:
  - `out_keep` and `out_data` clear.
  - If a pop also occurs in that same cycle, the popped byte lands in lane 0, `keep`=0001, `idx`=1, and the state goes to FILL.
  - Otherwise `idx`=0 and the state goes to FILL.
- `out_data` and `out_keep` are held stable while `out_valid && !out_ready`.
- `out_ready` is ignored while `out_valid`=0.
- Unfilled lanes read as zero.
- A reset mid-word discards the partial word; no flush occurs.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_keep`=0, `fifo_pop`=0, `idx`=0, state=FILL.
- `fifo_data` is sampled on the same `rdclk` edge at which `fifo_pop` is high.
- Latency: if the LANES-th byte is popped at edge k, `out_valid`=1 after edge k.
- Throughput: one entry per cycle while the FIFO is non-empty and the downstream is always ready. Back-to-back words need no bubble, thanks to the lane-0 pop in HOLD.
- A FIFO empty flag of 1 that is already registered in the FIFO is honoured as-is. The packer never pops when `fifo_empty`=1.

## Configuration
- `FIFO_PACK_TIMEOUT_EN` defined:
  - An idle counter, `$clog2(TMO+1)` bits, runs in FILL while `idx`>0 and `fifo_empty`=1.
  - The counter clears on any pop, on entry to FILL, and on reset.
  - When the counter reaches TMO, the block goes to HOLD with the partial `out_keep`, and `idx` is set to 0.
  - The timeout never fires when `idx`=0.
- `FIFO_PACK_TIMEOUT_EN` undefined:
  - No counter is built and `TMO` is ignored.
  - A partial word waits indefinitely for more data.
  - `out_keep` is then always all-ones when `out_valid`=1.

## Structure
- Shared package `fifo_pack_pkg` holds:
  - the state enum `pack_state_t` (FILL, HOLD);
  - a `lane_w(LANES)` constant function;
  - the keep-mask reset constant.
- Sub-module `fifo_pack_tmo` contains the idle counter with inputs `clr`, `run` and output `expire`. It is instantiated only under `FIFO_PACK_TIMEOUT_EN`.

## Test plan
- Reset, then FIFO with bytes 0x11,0x22,0x33,0x44 and `out_ready`=1 → one word, `out_data`=0x44332211, `out_keep`=1111, `out_valid` for exactly 1 cycle.
- 8 bytes 0x01..0x08, `out_ready` held 0 for 5 cycles → `out_data`=0x04030201 stable for the stall and `fifo_pop`=0. After release, 0x08070605 follows with no bubble.
- FIFO never empty, `out_ready`=1 → pops every cycle and `out_valid` every 4th cycle; 64 bytes yield 16 words in order.
- Timeout build, TMO=16, only 0xAA,0xBB written → 16 idle cycles later `out_data`=0x0000BBAA, `out_keep`=0011.
- Non-timeout build, same stimulus → `out_valid` stays 0 for 100 cycles. A third and fourth byte then yield `out_keep`=1111.
- `rdrst` pulsed after 2 of 4 bytes → `out_valid`=0 and `out_keep`=0. The next 4 bytes form a clean word starting at lane 0.
